// File: rtl/snn_neuron_scheduler_if.sv
// Event-in / spike-out handshake bundle for the scheduled LIF neuron array.
// The master side produces input events and consumes spike events.
interface snn_neuron_scheduler_if #(
  parameter int AW = 2,
  parameter int MW = 8
);
  logic          ev_valid;
  logic          ev_ready;
  logic [AW-1:0] ev_addr;
  logic [MW-1:0] ev_weight;
  logic          spike_valid;
  logic [AW-1:0] spike_addr;

  modport master (
    output ev_valid, ev_addr, ev_weight,
    input  ev_ready, spike_valid, spike_addr
  );

  modport slave (
    input  ev_valid, ev_addr, ev_weight,
    output ev_ready, spike_valid, spike_addr
  );
endinterface

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed leaky integrate-and-fire datapath over N_NEURONS virtual neurons.
// Events integrate in IDLE; each tick runs one leak sweep across the membrane file.
//
//   state | meaning
//   IDLE  | accepting weighted events, waiting for a tick
//   LEAK  | sweeping idx 0..N_NEURONS-1, one leak update per cycle
module snn_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int AW        = $clog2(N_NEURONS),
  parameter int MW        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic [MW-1:0]          threshold,
  input  logic [2:0]             leak_shift,
  snn_neuron_scheduler_if.slave  ev,
  output logic                   busy,
  output logic [7:0]             timestep,
  output logic                   tick_overrun
);

  typedef enum logic {IDLE, LEAK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] idx;
  logic          tick_pending;
  logic [MW-1:0] mem [N_NEURONS];

  logic          accept;
  logic          fire;
  logic          last_idx;
  logic          sweep_start;
  logic [MW-1:0] mem_ev;
  logic [MW:0]   sum_raw;
  logic [MW-1:0] sum_sat;
  logic [MW-1:0] mem_lk;
  logic [MW-1:0] leak_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick || tick_pending) state_nxt = LEAK;
      LEAK:    if (last_idx)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ev.ev_ready = (state == IDLE) && !tick && !tick_pending;
    busy        = (state == LEAK);
  end

  // Membrane file is read combinationally, so back-to-back events to one
  // neuron naturally see the value written on the previous edge.
  always_comb begin
    accept      = ev.ev_valid && ev.ev_ready;
    last_idx    = (idx == AW'(N_NEURONS - 1));
    sweep_start = (state == IDLE) && (state_nxt == LEAK);
    mem_ev      = mem[ev.ev_addr];
    sum_raw     = {1'b0, mem_ev} + {1'b0, ev.ev_weight};
    sum_sat     = sum_raw[MW] ? '1 : sum_raw[MW-1:0];
    fire        = accept && (sum_sat >= threshold);
    mem_lk      = mem[idx];
    leak_val    = (leak_shift == 3'd0) ? mem_lk : (mem_lk - (mem_lk >> leak_shift));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      tick_pending <= 1'b0;
      tick_overrun <= 1'b0;
      timestep     <= 8'd0;
    end else if (sweep_start) begin
      idx          <= '0;
      // a fresh tick arriving while a pending one is consumed stays queued
      tick_pending <= tick && tick_pending;
    end else if (state == LEAK) begin
      idx <= idx + 1'b1;
      if (tick) begin
        if (tick_pending) tick_overrun <= 1'b1;
        else              tick_pending <= 1'b1;
      end
      if (last_idx) timestep <= timestep + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev.spike_valid <= 1'b0;
      ev.spike_addr  <= '0;
    end else begin
      ev.spike_valid <= fire;
      if (fire) ev.spike_addr <= ev.ev_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) mem[k] <= '0;
    end else if (accept) begin
      mem[ev.ev_addr] <= fire ? '0 : sum_sat;
    end else if (state == LEAK) begin
      mem[idx] <= leak_val;
    end
  end

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// Directed bench for snn_neuron_scheduler: integrate/fire, saturation, leak,
// tick/event collision, overrun and asynchronous reset.
module tb_snn_neuron_scheduler;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [MW-1:0] threshold;
  logic [2:0]    leak_shift;
  logic          busy;
  logic [7:0]    timestep;
  logic          tick_overrun;

  int checks   = 0;
  int failures = 0;

  snn_neuron_scheduler_if #(.AW(AW), .MW(MW)) ev ();

  snn_neuron_scheduler #(.N_NEURONS(N), .AW(AW), .MW(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .threshold    (threshold),
    .leak_shift   (leak_shift),
    .ev           (ev.slave),
    .busy         (busy),
    .timestep     (timestep),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      cyc();
    end
  endtask

  task automatic send(input int addr, input int w);
    ev.ev_valid  = 1'b1;
    ev.ev_addr   = AW'(addr);
    ev.ev_weight = MW'(w);
    cyc();
    ev.ev_valid  = 1'b0;
  endtask

  int n_busy;
  int guard;
  bit ready_bad;

  initial begin
    rst_n        = 1'b0;
    tick         = 1'b0;
    threshold    = 8'd100;
    leak_shift   = 3'd0;
    ev.ev_valid  = 1'b0;
    ev.ev_addr   = '0;
    ev.ev_weight = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_busy", int'(busy), 0);
    chk("rst_timestep", int'(timestep), 0);
    chk("rst_spike_valid", int'(ev.spike_valid), 0);
    chk("rst_spike_addr", int'(ev.spike_addr), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    chk("rst_ev_ready", int'(ev.ev_ready), 1);

    // integrate 40+40+40 on neuron 2, threshold 100
    ev.ev_valid = 1'b1; ev.ev_addr = 2'd2; ev.ev_weight = 8'd40;
    cyc();
    chk("int1_spike", int'(ev.spike_valid), 0);
    chk("int1_mem", int'(dut.mem[2]), 40);
    cyc();
    chk("int2_spike", int'(ev.spike_valid), 0);
    chk("int2_mem", int'(dut.mem[2]), 80);
    cyc();
    ev.ev_valid = 1'b0;
    chk("int3_spike", int'(ev.spike_valid), 1);
    chk("int3_addr", int'(ev.spike_addr), 2);
    chk("int3_mem", int'(dut.mem[2]), 0);
    cyc();
    chk("int_spike_one_cycle", int'(ev.spike_valid), 0);
    chk("int_addr_hold", int'(ev.spike_addr), 2);

    // saturation: 200 + 200 -> 255 >= 255
    threshold = 8'd255;
    send(1, 200);
    chk("sat1_spike", int'(ev.spike_valid), 0);
    chk("sat1_mem", int'(dut.mem[1]), 200);
    send(1, 200);
    chk("sat2_spike", int'(ev.spike_valid), 1);
    chk("sat2_addr", int'(ev.spike_addr), 1);
    chk("sat2_mem", int'(dut.mem[1]), 0);

    // leak: 80 - (80>>2) = 60
    send(0, 80);
    chk("leak_pre_mem", int'(dut.mem[0]), 80);
    leak_shift = 3'd2;
    tick = 1'b1;
    @(negedge clk);
    chk("leak_tick_ready", int'(ev.ev_ready), 0);
    cyc();
    tick = 1'b0;
    run_sweep(n_busy);
    chk("leak_busy_cycles", n_busy, 4);
    chk("leak_mem0", int'(dut.mem[0]), 60);
    chk("leak_timestep", int'(timestep), 1);
    threshold = 8'd100;
    send(0, 39);
    chk("leak_99_spike", int'(ev.spike_valid), 0);
    chk("leak_99_mem", int'(dut.mem[0]), 99);
    send(0, 1);
    chk("leak_100_spike", int'(ev.spike_valid), 1);
    chk("leak_100_addr", int'(ev.spike_addr), 0);

    // tick and event in the same IDLE cycle
    threshold  = 8'd255;
    leak_shift = 3'd0;
    tick = 1'b1;
    ev.ev_valid = 1'b1; ev.ev_addr = 2'd3; ev.ev_weight = 8'd5;
    @(negedge clk);
    chk("col_ready_tick", int'(ev.ev_ready), 0);
    cyc();
    tick = 1'b0;
    ready_bad = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      if (ev.ev_ready) ready_bad = 1'b1;
      cyc();
      guard++;
    end
    chk("col_sweep_len", guard, 4);
    chk("col_no_ready_busy", int'(ready_bad), 0);
    chk("col_mem_untouched", int'(dut.mem[3]), 0);
    @(negedge clk);
    chk("col_ready_after", int'(ev.ev_ready), 1);
    cyc();
    ev.ev_valid = 1'b0;
    chk("col_mem3", int'(dut.mem[3]), 5);
    chk("col_timestep", int'(timestep), 2);

    // leak_shift=1: 7 -> 4, 5 -> 3
    send(2, 7);
    leak_shift = 3'd1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    run_sweep(n_busy);
    chk("half_mem2", int'(dut.mem[2]), 4);
    chk("half_mem3", int'(dut.mem[3]), 3);
    chk("half_timestep", int'(timestep), 3);
    chk("half_no_spike", int'(ev.spike_valid), 0);

    // overrun: three ticks inside one sweep
    leak_shift = 3'd0;
    tick = 1'b1;
    cyc();
    chk("ovr_busy_start", int'(busy), 1);
    cyc();
    cyc();
    cyc();
    tick = 1'b0;
    chk("ovr_flag", int'(tick_overrun), 1);
    cyc();
    chk("ovr_gap_busy", int'(busy), 0);
    @(negedge clk);
    chk("ovr_gap_ready", int'(ev.ev_ready), 0);
    cyc();
    chk("ovr_second_busy", int'(busy), 1);
    run_sweep(n_busy);
    chk("ovr_second_len", n_busy, 4);
    chk("ovr_timestep", int'(timestep), 5);
    cyc();
    chk("ovr_no_third", int'(busy), 0);
    chk("ovr_sticky", int'(tick_overrun), 1);

    // threshold 0 fires on any accepted event
    threshold = 8'd0;
    send(1, 0);
    chk("thr0_spike", int'(ev.spike_valid), 1);
    chk("thr0_addr", int'(ev.spike_addr), 1);

    // asynchronous reset in the middle of a sweep
    threshold = 8'd255;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    chk("ar_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_timestep", int'(timestep), 0);
    chk("ar_overrun", int'(tick_overrun), 0);
    chk("ar_spike_valid", int'(ev.spike_valid), 0);
    for (int k = 0; k < N; k++) chk($sformatf("ar_mem%0d", k), int'(dut.mem[k]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ar_ready_after", int'(ev.ev_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snn_neuron_scheduler.md
Name: snn_neuron_scheduler

Overview:
- Time-multiplexes one leaky integrate-and-fire update datapath over N_NEURONS virtual neurons. Membrane state is held in an internal register file.
- Accepts weighted input events over a valid/ready handshake.
- Runs one leak sweep over all neurons on each timestep tick and emits addressed spike events.
- Sits between the top-level I/O pins and the spiking neuron datapath, replacing the single hard-wired neuron with a scheduled array.

Parameters:
- N_NEURONS, 4, number of virtual neurons; power of two, 2..16.
- AW, $clog2(N_NEURONS), width of neuron address.
- MW, 8, membrane and weight width in bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tick  input  1  single-cycle pulse that starts a timestep (leak sweep).
- ev_valid  input  1  input event valid.
- ev_ready  output  1  scheduler can accept an event this cycle.
- ev_addr  input  AW  target neuron of the event.
- ev_weight  input  MW  unsigned weight added to the target membrane.
- threshold  input  MW  firing threshold; sampled combinationally on each accepted event.
- leak_shift  input  3  leak amount: mem -= mem>>leak_shift; value 0 disables leak.
- spike_valid  output  1  one-cycle spike pulse; no backpressure.
- spike_addr  output  AW  neuron that fired; valid only while spike_valid is high.
- busy  output  1  leak sweep in progress.
- timestep  output  8  count of completed sweeps; wraps 255->0.
- tick_overrun  output  1  sticky flag; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low; all state is cleared immediately on assertion, mid-operation included.
- Reset values:
  - All membranes = 0.
  - State = IDLE; tick_pending = 0.
  - spike_valid = 0, spike_addr = 0, busy = 0, timestep = 0, tick_overrun = 0.
- FSM states:
  - IDLE: events are accepted.
  - LEAK: sweep index i runs 0..N_NEURONS-1, one neuron per cycle.
- IDLE to LEAK: when tick=1 or tick_pending=1. Set i=0, clear tick_pending; busy goes high the next cycle.
- LEAK to IDLE: after the cycle in which i = N_NEURONS-1 is updated. timestep increments on that same edge.
- Sweep length: exactly N_NEURONS cycles with busy=1.
- ev_ready = (state==IDLE) && !tick && !tick_pending. A tick wins over a simultaneous event: the event is held off by the handshake and is not dropped.
- Event accept (ev_valid && ev_ready): sum = mem[ev_addr] + ev_weight, saturating at 2^MW-1.
  - If sum >= threshold: mem <= 0, and spike_valid=1, spike_addr=ev_addr on the next cycle.
  - Otherwise mem <= sum and no spike.
  - threshold=0 makes every accepted event fire.
- Event throughput: 1 event per cycle in IDLE. Back-to-back events to the same neuron must use the updated value (no read-after-write hazard).
- Leak step: mem[i] <= mem[i] - (mem[i] >> leak_shift).
  - leak_shift=0 leaves mem unchanged.
  - leak_shift=1 halves mem, rounding toward the larger remainder: 7 -> 4.
  - Leak never produces a spike.
- Tick during LEAK:
  - If tick_pending=0, set tick_pending=1; the next sweep starts right after the current one (one IDLE cycle, with ev_ready=0).
  - If tick_pending=1 already, set tick_overrun=1 and drop the extra tick.
- Tick in the last LEAK cycle: counts as during LEAK (sets pending).
- Out-of-range ev_addr (possible only if N_NEURONS is not a power of two): not allowed, since N_NEURONS is restricted to powers of two.
- spike_valid is high for exactly one cycle per firing event. spike_addr holds its last value otherwise.
- Config inputs threshold and leak_shift must be stable while in use. They are not registered.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-sweep -> busy=0, timestep=0, all membranes 0, spike_valid=0 immediately, without waiting for a clk edge.
- Integrate/fire: threshold=100, leak_shift=0, events to addr 2 with weight 40, 40, 40 back-to-back -> no spike after events 1 and 2; spike_valid=1, spike_addr=2 the cycle after event 3; mem[2]=0.
- Saturation: threshold=255, events of weight 200 then 200 to addr 1 -> sum saturates at 255 and fires; spike_addr=1.
- Leak: mem[0]=80, leak_shift=2, one tick -> busy=1 for 4 cycles, mem[0]=60, timestep=1; then one event of weight 39 with threshold=100 -> no spike (99).
- Tick/event collision: tick and ev_valid in the same IDLE cycle -> ev_ready=0; event is accepted on the first IDLE cycle after the sweep; no event is lost.
- Overrun: three ticks during one sweep -> one extra sweep runs back-to-back, tick_overrun=1 sticky, timestep advances by 2 in total.
